// File: rtl/taxi_fare_counter_if.sv
// Taximeter command/display bundle: wheel pulse and trip commands in,
// seven BCD display digits plus status flags out.
interface taxi_fare_counter_if;
   logic       pulse_in;
   logic       start;
   logic       stop;
   logic       clear;
   logic [3:0] distan_count_thous;
   logic [3:0] distan_count_hundr;
   logic [3:0] distan_count_tens;
   logic [3:0] distan_count_units;
   logic [3:0] price_count_hundr;
   logic [3:0] price_count_tens;
   logic [3:0] price_count_units;
   logic       running;
   logic       waiting;

   // Controller side: issues commands and the sensor pulse, reads the display.
   modport master (
      output pulse_in, start, stop, clear,
      input  distan_count_thous, distan_count_hundr, distan_count_tens, distan_count_units,
      input  price_count_hundr, price_count_tens, price_count_units,
      input  running, waiting
   );

   // Meter side: the taxi_fare_counter core.
   modport slave (
      input  pulse_in, start, stop, clear,
      output distan_count_thous, distan_count_hundr, distan_count_tens, distan_count_units,
      output price_count_hundr, price_count_tens, price_count_units,
      output running, waiting
   );
endinterface

// File: rtl/taxi_fare_counter.sv
// Taximeter trip metering core: synchronises the wheel pulse, counts BCD
// metres (X.XXX km) and accumulates the BCD fare (XX.X yuan), both saturating.
// Optional waiting fare is built only when WAIT_FARE_EN is defined.
module taxi_fare_counter #(
   parameter int unsigned PULSES_PER_M   = 4,
   parameter int unsigned BASE_DIST_M    = 3000,
   parameter int unsigned M_PER_TENTH    = 50,
   parameter logic [3:0]  BASE_FARE_H    = 4'd1,
   parameter logic [3:0]  BASE_FARE_T    = 4'd0,
   parameter logic [3:0]  BASE_FARE_U    = 4'd0,
   parameter int unsigned WAIT_IDLE_CYC  = 50_000_000,
   parameter int unsigned WAIT_TENTH_CYC = 30_000_000
) (
   input logic                clk,
   input logic                rst,
   taxi_fare_counter_if.slave bus
);

   localparam int PS_W = (PULSES_PER_M > 1) ? $clog2(PULSES_PER_M) : 1;
   localparam int ST_W = (M_PER_TENTH > 1) ? $clog2(M_PER_TENTH) : 1;

   if (PULSES_PER_M < 1 || M_PER_TENTH < 1 || BASE_DIST_M > 9999 ||
       WAIT_IDLE_CYC < 1 || WAIT_TENTH_CYC < 1) begin : g_param_check
      $error("taxi_fare_counter: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t            r_state;
   logic              r_running;
   logic [15:0]       r_dist;      // BCD metres, thousands digit first
   logic [11:0]       r_fare;      // BCD tenths of a yuan
   logic [13:0]       r_metres;    // binary shadow of r_dist
   logic [PS_W-1:0]   r_pres;
   logic [ST_W-1:0]   r_step;
   logic              r_sync1, r_sync2, r_sync3;

   logic              w_rise;
   logic              w_pres_wrap;
   logic              w_metre_inc;
   logic              w_dist_tick;
   logic              w_wait_tick;
   logic [1:0]        w_fare_add;

   // Cascaded BCD +1 over four digits; caller guarantees the input is below 9999.
   function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Three-digit BCD add of 0..2 tenths, clamped at 99.9.
   function automatic logic [11:0] bcd3_add(input logic [11:0] v, input logic [1:0] add);
      logic [4:0] u, t, h;
      u = {1'b0, v[3:0]} + {3'b000, add};
      t = {1'b0, v[7:4]};
      h = {1'b0, v[11:8]};
      if (u >= 5'd10) begin
         u = u - 5'd10;
         t = t + 5'd1;
      end
      if (t >= 5'd10) begin
         t = t - 5'd10;
         h = h + 5'd1;
      end
      if (h >= 5'd10) return 12'h999;
      return {h[3:0], t[3:0], u[3:0]};
   endfunction

   // Two-flop synchroniser for the wheel sensor plus one delay flop for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
         r_sync1 <= bus.pulse_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_rise      = r_sync2 & ~r_sync3;
   assign w_pres_wrap = w_rise && (r_pres == PS_W'(PULSES_PER_M - 1));
   // Metres past 9.999 are dropped entirely: no distance, fare or wait effect.
   assign w_metre_inc = (r_state == S_RUN) && w_pres_wrap && (r_dist != 16'h9999);
   assign w_dist_tick = w_metre_inc && (r_metres >= 14'(BASE_DIST_M)) &&
                        (r_step == ST_W'(M_PER_TENTH - 1));
   assign w_fare_add  = {1'b0, w_dist_tick} + {1'b0, w_wait_tick};

`ifdef WAIT_FARE_EN
   localparam int IW = (WAIT_IDLE_CYC > 1) ? $clog2(WAIT_IDLE_CYC) : 1;
   localparam int WW = (WAIT_TENTH_CYC > 1) ? $clog2(WAIT_TENTH_CYC) : 1;

   logic [IW-1:0] r_idle;
   logic [WW-1:0] r_wt;
   logic          r_waiting;

   assign w_wait_tick = (r_state == S_RUN) && r_waiting && !w_metre_inc &&
                        (r_wt == WW'(WAIT_TENTH_CYC - 1));
   assign bus.waiting = r_waiting;
`else
   assign w_wait_tick = 1'b0;
   assign bus.waiting = 1'b0;
`endif

   // Trip FSM with command priority clear > stop > start, plus all metering state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.clear) begin
         r_state   <= S_IDLE;
         r_running <= 1'b0;
         r_dist    <= '0;
         r_fare    <= '0;
         r_metres  <= '0;
         r_pres    <= '0;
         r_step    <= '0;
`ifdef WAIT_FARE_EN
         r_idle    <= '0;
         r_wt      <= '0;
         r_waiting <= 1'b0;
`endif
      end else if (bus.stop) begin
         if (r_state == S_RUN) begin
            r_state   <= S_HOLD;
            r_running <= 1'b0;
`ifdef WAIT_FARE_EN
            r_waiting <= 1'b0;
`endif
         end
      end else if (bus.start && r_state != S_RUN) begin
         r_state   <= S_RUN;
         r_running <= 1'b1;
         r_dist    <= '0;
         r_fare    <= {BASE_FARE_H, BASE_FARE_T, BASE_FARE_U};
         r_metres  <= '0;
         r_pres    <= '0;
         r_step    <= '0;
`ifdef WAIT_FARE_EN
         r_idle    <= '0;
         r_wt      <= '0;
         r_waiting <= 1'b0;
`endif
      end else if (r_state == S_RUN) begin
         if (w_rise) r_pres <= w_pres_wrap ? '0 : r_pres + PS_W'(1);
         if (w_metre_inc) begin
            r_dist   <= bcd4_inc(r_dist);
            r_metres <= r_metres + 14'd1;
            if (r_metres >= 14'(BASE_DIST_M))
               r_step <= (r_step == ST_W'(M_PER_TENTH - 1)) ? '0 : r_step + ST_W'(1);
         end
         if (w_fare_add != 2'd0) r_fare <= bcd3_add(r_fare, w_fare_add);
`ifdef WAIT_FARE_EN
         if (w_metre_inc) begin
            r_idle    <= '0;
            r_wt      <= '0;
            r_waiting <= 1'b0;
         end else if (r_waiting) begin
            r_wt <= (r_wt == WW'(WAIT_TENTH_CYC - 1)) ? '0 : r_wt + WW'(1);
         end else if (r_idle == IW'(WAIT_IDLE_CYC - 1)) begin
            r_waiting <= 1'b1;
         end else begin
            r_idle <= r_idle + IW'(1);
         end
`endif
      end
   end

   assign bus.distan_count_thous = r_dist[15:12];
   assign bus.distan_count_hundr = r_dist[11:8];
   assign bus.distan_count_tens  = r_dist[7:4];
   assign bus.distan_count_units = r_dist[3:0];
   assign bus.price_count_hundr  = r_fare[11:8];
   assign bus.price_count_tens   = r_fare[7:4];
   assign bus.price_count_units  = r_fare[3:0];
   assign bus.running            = r_running;

endmodule

// File: tb/tb_taxi_fare_counter.sv
// Self-checking bench for taxi_fare_counter with small trip parameters.
// Expected values come from an integer trip model (metres, tenths, idle cycles).
module tb_taxi_fare_counter;
   localparam int PPM = 1, BASE = 20, MPT = 5, WIDLE = 10, WTENTH = 4;
`ifdef WAIT_FARE_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   taxi_fare_counter_if bus_if();

   taxi_fare_counter #(
      .PULSES_PER_M(PPM), .BASE_DIST_M(BASE), .M_PER_TENTH(MPT),
      .BASE_FARE_H(4'd1), .BASE_FARE_T(4'd0), .BASE_FARE_U(4'd0),
      .WAIT_IDLE_CYC(WIDLE), .WAIT_TENTH_CYC(WTENTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Trip model state
   typedef enum {M_IDLE, M_RUN, M_HOLD} mstate_t;
   mstate_t m_st;
   int      m_metres, m_pres, m_idle, m_wcnt, m_wtenths;
   bit      m_waiting;
   bit      m_hist[3];   // pulse samples from 1, 2, 3 edges ago

   task automatic model_idle();
      m_st = M_IDLE; m_metres = 0; m_pres = 0; m_idle = 0;
      m_wcnt = 0; m_wtenths = 0; m_waiting = 0;
   endtask

   task automatic model_reset();
      model_idle();
      m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
   endtask

   // One clock edge of trip behaviour with the command/pulse inputs seen there.
   task automatic model_step(input bit st, input bit sp, input bit cl, input bit pu);
      bit rise, metre_ev;
      rise = m_hist[1] && !m_hist[2];
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = pu;
      if (cl) model_idle();
      else if (sp) begin
         if (m_st == M_RUN) begin m_st = M_HOLD; m_waiting = 0; end
      end else if (st && m_st != M_RUN) begin
         model_idle();
         m_st = M_RUN;
      end else if (m_st == M_RUN) begin
         metre_ev = 0;
         if (rise) begin
            m_pres++;
            if (m_pres == PPM) begin
               m_pres = 0;
               if (m_metres < 9999) begin m_metres++; metre_ev = 1; end
            end
         end
         if (WAIT_EN) begin
            if (metre_ev) begin m_idle = 0; m_wcnt = 0; m_waiting = 0; end
            else if (m_waiting) begin
               m_wcnt++;
               if (m_wcnt == WTENTH) begin m_wcnt = 0; m_wtenths++; end
            end else begin
               m_idle++;
               if (m_idle == WIDLE) m_waiting = 1;
            end
         end
      end
   endtask

   function automatic int model_fare();
      int d, f;
      if (m_st == M_IDLE) return 0;
      d = (m_metres > BASE) ? (m_metres - BASE) / MPT : 0;
      f = 100 + d + m_wtenths;
      return (f > 999) ? 999 : f;
   endfunction

   // {4 distance digits, 3 fare digits, running, waiting}
   function automatic logic [29:0] exp_vec();
      int f;
      f = model_fare();
      return {4'((m_metres / 1000) % 10), 4'((m_metres / 100) % 10),
              4'((m_metres / 10) % 10), 4'(m_metres % 10),
              4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10),
              (m_st == M_RUN), m_waiting};
   endfunction

   function automatic logic [29:0] act_vec();
      return {bus_if.distan_count_thous, bus_if.distan_count_hundr,
              bus_if.distan_count_tens, bus_if.distan_count_units,
              bus_if.price_count_hundr, bus_if.price_count_tens,
              bus_if.price_count_units, bus_if.running, bus_if.waiting};
   endfunction

   // Drive inputs at the falling edge, advance one rising edge, sample 1 time unit later.
   task automatic cycle(input bit st, input bit sp, input bit cl, input bit pu);
      @(negedge clk);
      bus_if.start = st; bus_if.stop = sp; bus_if.clear = cl; bus_if.pulse_in = pu;
      @(posedge clk);
      model_step(st, sp, cl, pu);
      #1;
   endtask

   // Each pulse is 2 cycles high then 2 low; the metre lands within the low phase.
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
         cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
      end
   endtask

   task automatic test_reset();
      logic [29:0] a;
      rst = 1'b1;
      bus_if.start = 0; bus_if.stop = 0; bus_if.clear = 0; bus_if.pulse_in = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 0, 0, 0);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL reset_state: got %h expected %h", a, 30'h0); end
      n_cmp++;
   endtask

   task automatic test_start_base();
      logic [29:0] a;
      cycle(1, 0, 0, 0);
      a = act_vec();
      if (a !== {16'h0000, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL start_load: got %h expected %h", a, {16'h0000, 12'h100, 2'b10});
      end
      n_cmp++;
      pulses(20);
      a = act_vec();
      if (a !== {16'h0020, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL base_distance_20m: got %h expected %h", a, {16'h0020, 12'h100, 2'b10});
      end
      n_cmp++;
      pulses(4);
      a = act_vec();
      if (a !== {16'h0024, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL before_first_step_24m: got %h expected %h", a, {16'h0024, 12'h100, 2'b10});
      end
      n_cmp++;
      pulses(1);
      a = act_vec();
      if (a !== {16'h0025, 12'h101, 2'b10}) begin
         n_bad++; $display("FAIL first_step_25m: got %h expected %h", a, {16'h0025, 12'h101, 2'b10});
      end
      n_cmp++;
      if (a !== exp_vec()) begin n_bad++; $display("FAIL model_after_25m: got %h expected %h", a, exp_vec()); end
      n_cmp++;
   endtask

   task automatic test_hold();
      logic [29:0] a;
      cycle(0, 0, 1, 0);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL clear_from_run: got %h expected %h", a, 30'h0); end
      n_cmp++;
      cycle(1, 0, 0, 0);
      pulses(3);
      cycle(1, 0, 0, 0);   // start is ignored while running
      a = act_vec();
      if (a !== {16'h0003, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL start_ignored_in_run: got %h expected %h", a, {16'h0003, 12'h100, 2'b10});
      end
      n_cmp++;
      cycle(0, 1, 0, 0);
      pulses(5);
      a = act_vec();
      if (a !== {16'h0003, 12'h100, 2'b00}) begin
         n_bad++; $display("FAIL hold_frozen: got %h expected %h", a, {16'h0003, 12'h100, 2'b00});
      end
      n_cmp++;
      cycle(1, 0, 0, 0);
      a = act_vec();
      if (a !== {16'h0000, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL restart_from_hold: got %h expected %h", a, {16'h0000, 12'h100, 2'b10});
      end
      n_cmp++;
      cycle(0, 0, 1, 0);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL clear_to_idle: got %h expected %h", a, 30'h0); end
      n_cmp++;
   endtask

   task automatic test_priority();
      logic [29:0] a;
      cycle(1, 1, 0, 0);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL start_stop_in_idle: got %h expected %h", a, 30'h0); end
      n_cmp++;
      cycle(1, 0, 0, 0);
      pulses(2);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 1, 0);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL clear_start_in_hold: got %h expected %h", a, 30'h0); end
      n_cmp++;
   endtask

   task automatic test_wait();
      logic [29:0] a;
      logic        w_exp;
      logic [11:0] f_exp;
      cycle(1, 0, 0, 0);
      repeat (9) cycle(0, 0, 0, 0);
      a = act_vec();
      if (a[0] !== 1'b0) begin n_bad++; $display("FAIL wait_not_yet_9cyc: got %b expected %b", a[0], 1'b0); end
      n_cmp++;
      cycle(0, 0, 0, 0);
      w_exp = WAIT_EN;
      a = act_vec();
      if (a[0] !== w_exp) begin n_bad++; $display("FAIL wait_flag_10cyc: got %b expected %b", a[0], w_exp); end
      n_cmp++;
      repeat (3) cycle(0, 0, 0, 0);
      a = act_vec();
      if (a[13:2] !== 12'h100) begin n_bad++; $display("FAIL wait_no_tick_yet: got %h expected %h", a[13:2], 12'h100); end
      n_cmp++;
      cycle(0, 0, 0, 0);
      f_exp = WAIT_EN ? 12'h101 : 12'h100;
      a = act_vec();
      if (a[13:2] !== f_exp) begin n_bad++; $display("FAIL wait_tick_price: got %h expected %h", a[13:2], f_exp); end
      n_cmp++;
      pulses(1);
      a = act_vec();
      if (a !== {16'h0001, f_exp, 2'b10}) begin
         n_bad++; $display("FAIL wait_cleared_by_metre: got %h expected %h", a, {16'h0001, f_exp, 2'b10});
      end
      n_cmp++;
      if (a !== exp_vec()) begin n_bad++; $display("FAIL model_after_wait: got %h expected %h", a, exp_vec()); end
      n_cmp++;
      cycle(0, 0, 1, 0);
   endtask

   task automatic test_saturation();
      logic [29:0] a;
      cycle(1, 0, 0, 0);
      pulses(9998);
      a = act_vec();
      if (a !== {16'h9998, 12'h999, 2'b10}) begin
         n_bad++; $display("FAIL distance_9998: got %h expected %h", a, {16'h9998, 12'h999, 2'b10});
      end
      n_cmp++;
      pulses(3);
      a = act_vec();
      if (a !== {16'h9999, 12'h999, 2'b10}) begin
         n_bad++; $display("FAIL saturate_9999: got %h expected %h", a, {16'h9999, 12'h999, 2'b10});
      end
      n_cmp++;
      if (a !== exp_vec()) begin n_bad++; $display("FAIL model_saturation: got %h expected %h", a, exp_vec()); end
      n_cmp++;
      cycle(0, 0, 1, 0);
   endtask

   task automatic test_reset_midtrip();
      logic [29:0] a;
      cycle(1, 0, 0, 0);
      pulses(12);
      a = act_vec();
      if (a[29:14] !== 16'h0012) begin n_bad++; $display("FAIL pre_reset_12m: got %h expected %h", a[29:14], 16'h0012); end
      n_cmp++;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL async_reset_immediate: got %h expected %h", a, 30'h0); end
      n_cmp++;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses(3);
      a = act_vec();
      if (a !== 30'h0) begin n_bad++; $display("FAIL pulses_ignored_idle: got %h expected %h", a, 30'h0); end
      n_cmp++;
      cycle(1, 0, 0, 0);
      pulses(2);
      a = act_vec();
      if (a !== {16'h0002, 12'h100, 2'b10}) begin
         n_bad++; $display("FAIL run_after_reset: got %h expected %h", a, {16'h0002, 12'h100, 2'b10});
      end
      n_cmp++;
   endtask

   // Random commands and pulse trains (held >=2 cycles), checked every cycle.
   task automatic test_random();
      logic [29:0] a, e;
      bit lvl;
      int hold, bad_here;
      bit st, sp, cl;
      lvl = 0; hold = 2; bad_here = 0;
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            lvl = !lvl;
            hold = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 30) : $urandom_range(2, 4);
         end
         hold--;
         st = ($urandom_range(0, 59) == 0);
         sp = ($urandom_range(0, 199) == 0);
         cl = ($urandom_range(0, 599) == 0);
         cycle(st, sp, cl, lvl);
         a = act_vec();
         e = exp_vec();
         if (a !== e) begin
            n_bad++;
            if (bad_here < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, a, e);
            bad_here++;
         end
         n_cmp++;
      end
   endtask

   initial begin
      test_reset();
      test_start_base();
      test_hold();
      test_priority();
      test_wait();
      test_saturation();
      test_reset_midtrip();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
